// File: rtl/dest_pkg.sv
// Shared types and level table for the destination-rectangle sequencer.
package dest_pkg;

    localparam int DEF_POS_W   = 12;
    localparam int DEF_COLOR_W = 4;
    localparam int TABLE_DEPTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW,
        ST_HIDE,
        ST_DONE
    } dest_state_t;

    // Per-level rectangle start position and colour, indexed by level.
    localparam logic [DEF_POS_W-1:0]   LVL_HPOS  [TABLE_DEPTH] = '{12'd100, 12'd400, 12'd620};
    localparam logic [DEF_POS_W-1:0]   LVL_VPOS  [TABLE_DEPTH] = '{12'd80,  12'd300, 12'd440};
    localparam logic [DEF_COLOR_W-1:0] LVL_COLOR [TABLE_DEPTH] = '{4'hA, 4'hC, 4'h5};

endpackage

// File: rtl/dest_level_rom.sv
// Combinational level -> {hPos, vPos, colour} lookup from the package table.
// Levels beyond the table (or beyond NUM_LEVELS) read back as all zeros.
module dest_level_rom
    import dest_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int LVL_W      = 2,
    parameter int POS_W      = DEF_POS_W,
    parameter int COLOR_W    = DEF_COLOR_W
) (
    input  logic [LVL_W-1:0]   level,
    output logic [POS_W-1:0]   h_pos,
    output logic [POS_W-1:0]   v_pos,
    output logic [COLOR_W-1:0] color
);

    // Select the table entry whose index matches the requested level.
    always_comb begin
        h_pos = '0;
        v_pos = '0;
        color = '0;
        for (int i = 0; i < TABLE_DEPTH; i++) begin
            if (i < NUM_LEVELS && level == LVL_W'(i)) begin
                h_pos = POS_W'(LVL_HPOS[i]);
                v_pos = POS_W'(LVL_VPOS[i]);
                color = COLOR_W'(LVL_COLOR[i]);
            end
        end
    end

endmodule

// File: rtl/dest_rect_sequencer.sv
// Steps the destination rectangle through the levels: shows it, hides it for
// a fixed gap after each completed level, then loads the next table entry.
module dest_rect_sequencer
    import dest_pkg::*;
#(
    parameter int NUM_LEVELS  = 3,
    parameter int POS_W       = DEF_POS_W,
    parameter int COLOR_W     = DEF_COLOR_W,
    parameter int HIDE_CYCLES = 4,
    localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               level_complete,
    output logic [POS_W-1:0]   dest_hPos,
    output logic [POS_W-1:0]   dest_vPos,
    output logic [COLOR_W-1:0] dest_color,
    output logic               dest_visible,
    output logic [LVL_W-1:0]   level,
    output logic               level_adv,
    output logic               game_done
);

    localparam int               CNT_W     = (HIDE_CYCLES > 1) ? $clog2(HIDE_CYCLES) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] HIDE_LOAD = CNT_W'(HIDE_CYCLES - 1);

    dest_state_t        state_reg,   state_next;
    logic [LVL_W-1:0]   level_reg,   level_next;
    logic [CNT_W-1:0]   hide_cnt_reg, hide_cnt_next;
    logic [POS_W-1:0]   hpos_reg,    hpos_next;
    logic [POS_W-1:0]   vpos_reg,    vpos_next;
    logic [COLOR_W-1:0] color_reg,   color_next;
    logic               visible_reg, visible_next;
    logic               adv_reg,     adv_next;
    logic               done_reg,    done_next;

    logic [POS_W-1:0]   rom_hpos;
    logic [POS_W-1:0]   rom_vpos;
    logic [COLOR_W-1:0] rom_color;

    dest_level_rom #(
        .NUM_LEVELS (NUM_LEVELS),
        .LVL_W      (LVL_W),
        .POS_W      (POS_W),
        .COLOR_W    (COLOR_W)
    ) u_rom (
        .level (level_reg),
        .h_pos (rom_hpos),
        .v_pos (rom_vpos),
        .color (rom_color)
    );

    // State, counters and every output are held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            level_reg    <= '0;
            hide_cnt_reg <= '0;
            hpos_reg     <= '0;
            vpos_reg     <= '0;
            color_reg    <= '0;
            visible_reg  <= 1'b0;
            adv_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            level_reg    <= level_next;
            hide_cnt_reg <= hide_cnt_next;
            hpos_reg     <= hpos_next;
            vpos_reg     <= vpos_next;
            color_reg    <= color_next;
            visible_reg  <= visible_next;
            adv_reg      <= adv_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and next-output logic; visibility follows the state being entered.
    always_comb begin
        state_next    = state_reg;
        level_next    = level_reg;
        hide_cnt_next = hide_cnt_reg;
        hpos_next     = hpos_reg;
        vpos_next     = vpos_reg;
        color_next    = color_reg;
        adv_next      = 1'b0;
        done_next     = done_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    level_next = '0;
                end
            end
            ST_LOAD: begin
                hpos_next  = rom_hpos;
                vpos_next  = rom_vpos;
                color_next = rom_color;
                state_next = ST_SHOW;
            end
            ST_SHOW: begin
                // start is deliberately not looked at here, so a coincident
                // level_complete always wins.
                if (level_complete) begin
                    if (level_reg == LAST_LVL) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next    = ST_HIDE;
                        level_next    = level_reg + 1'b1;
                        adv_next      = 1'b1;
                        hide_cnt_next = HIDE_LOAD;
                    end
                end
            end
            ST_HIDE: begin
                if (hide_cnt_reg == '0) begin
                    state_next = ST_LOAD;
                end else begin
                    hide_cnt_next = hide_cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    level_next = '0;
                    done_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        visible_next = (state_next == ST_SHOW);
    end

    assign dest_hPos    = hpos_reg;
    assign dest_vPos    = vpos_reg;
    assign dest_color   = color_reg;
    assign dest_visible = visible_reg;
    assign level        = level_reg;
    assign level_adv    = adv_reg;
    assign game_done    = done_reg;

endmodule

// File: tb/tb_dest_rect_sequencer.sv
// Directed bench for dest_rect_sequencer (3 levels, 4-cycle hide gap).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_dest_rect_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        level_complete;
    logic [11:0] dest_hPos;
    logic [11:0] dest_vPos;
    logic [3:0]  dest_color;
    logic        dest_visible;
    logic [1:0]  level;
    logic        level_adv;
    logic        game_done;

    int total = 0;
    int bad   = 0;

    // {visible, level, hPos, vPos, color, level_adv, game_done}
    logic [32:0] outs;
    assign outs = {dest_visible, level, dest_hPos, dest_vPos, dest_color, level_adv, game_done};

    dest_rect_sequencer #(
        .NUM_LEVELS  (3),
        .POS_W       (12),
        .COLOR_W     (4),
        .HIDE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .level_complete (level_complete),
        .dest_hPos      (dest_hPos),
        .dest_vPos      (dest_vPos),
        .dest_color     (dest_color),
        .dest_visible   (dest_visible),
        .level          (level),
        .level_adv      (level_adv),
        .game_done      (game_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        $display("txn test_reset");
        rst_n = 1'b1; start = 1'b0; level_complete = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        exp = '0;
        total++;
        if (outs !== exp) begin bad++; $display("FAIL reset_values got=%h want=%h", outs, exp); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);
        total++;
        if (outs !== exp) begin bad++; $display("FAIL idle_after_release got=%h want=%h", outs, exp); end
    endtask

    task automatic test_start();
        logic [32:0] exp;
        $display("txn test_start");
        start = 1'b1; tick(1); start = 1'b0;
        exp = '0;
        total++;
        if (outs !== exp) begin bad++; $display("FAIL start_load_cycle got=%h want=%h", outs, exp); end
        tick(1);
        exp = {1'b1, 2'd0, 12'd100, 12'd80, 4'hA, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL start_show_l0 got=%h want=%h", outs, exp); end
    endtask

    task automatic test_level_advance();
        logic [32:0] exp;
        $display("txn test_level_advance");
        level_complete = 1'b1; tick(1); level_complete = 1'b0;
        exp = {1'b0, 2'd1, 12'd100, 12'd80, 4'hA, 1'b1, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL adv_first_edge got=%h want=%h", outs, exp); end
        tick(1);
        exp = {1'b0, 2'd1, 12'd100, 12'd80, 4'hA, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL adv_pulse_width got=%h want=%h", outs, exp); end
        tick(3);
        total++;
        if (outs !== exp) begin bad++; $display("FAIL hidden_edge5 got=%h want=%h", outs, exp); end
        tick(1);
        exp = {1'b1, 2'd1, 12'd400, 12'd300, 4'hC, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL show_l1_edge6 got=%h want=%h", outs, exp); end
    endtask

    task automatic test_game_done();
        logic [32:0] exp;
        $display("txn test_game_done");
        level_complete = 1'b1; tick(1); level_complete = 1'b0;
        exp = {1'b0, 2'd2, 12'd400, 12'd300, 4'hC, 1'b1, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL adv_to_l2 got=%h want=%h", outs, exp); end
        tick(5);
        exp = {1'b1, 2'd2, 12'd620, 12'd440, 4'h5, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL show_l2 got=%h want=%h", outs, exp); end
        level_complete = 1'b1; tick(1); level_complete = 1'b0;
        exp = {1'b0, 2'd2, 12'd620, 12'd440, 4'h5, 1'b0, 1'b1};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL done_no_adv got=%h want=%h", outs, exp); end
        level_complete = 1'b1; tick(3); level_complete = 1'b0;
        tick(1);
        total++;
        if (outs !== exp) begin bad++; $display("FAIL done_held got=%h want=%h", outs, exp); end
    endtask

    task automatic test_restart_from_done();
        logic [32:0] exp;
        $display("txn test_restart_from_done");
        start = 1'b1; tick(1); start = 1'b0;
        exp = {1'b0, 2'd0, 12'd620, 12'd440, 4'h5, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL restart_load got=%h want=%h", outs, exp); end
        tick(1);
        exp = {1'b1, 2'd0, 12'd100, 12'd80, 4'hA, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL restart_show_l0 got=%h want=%h", outs, exp); end
    endtask

    task automatic test_held_level_complete();
        logic [32:0] exp;
        int adv_seen;
        $display("txn test_held_level_complete");
        adv_seen = 0;
        // Held through the SHOW edge and the whole hide/load window.
        level_complete = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            if (level_adv === 1'b1) adv_seen++;
        end
        level_complete = 1'b0;
        exp = {1'b1, 2'd1, 12'd400, 12'd300, 4'hC, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL held_lc_single_adv got=%h want=%h", outs, exp); end
        total++;
        if (adv_seen !== 1) begin bad++; $display("FAIL held_lc_adv_count got=%0d want=1", adv_seen); end
        start = 1'b1; level_complete = 1'b1; tick(1);
        start = 1'b0; level_complete = 1'b0;
        exp = {1'b0, 2'd2, 12'd400, 12'd300, 4'hC, 1'b1, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL start_lc_same_cycle got=%h want=%h", outs, exp); end
        tick(5);
        exp = {1'b1, 2'd2, 12'd620, 12'd440, 4'h5, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL no_restart_show_l2 got=%h want=%h", outs, exp); end
    endtask

    task automatic test_reset_in_hide();
        logic [32:0] exp;
        $display("txn test_reset_in_hide");
        level_complete = 1'b1; tick(1); level_complete = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        level_complete = 1'b1; tick(1); level_complete = 1'b0;
        tick(1);
        exp = {1'b0, 2'd1, 12'd100, 12'd80, 4'hA, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL in_hide_before_reset got=%h want=%h", outs, exp); end
        #2 rst_n = 1'b0;
        #1;
        exp = '0;
        total++;
        if (outs !== exp) begin bad++; $display("FAIL async_reset_mid_hide got=%h want=%h", outs, exp); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(6);
        total++;
        if (outs !== exp) begin bad++; $display("FAIL idle_waits_for_start got=%h want=%h", outs, exp); end
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        exp = {1'b1, 2'd0, 12'd100, 12'd80, 4'hA, 1'b0, 1'b0};
        total++;
        if (outs !== exp) begin bad++; $display("FAIL post_reset_show_l0 got=%h want=%h", outs, exp); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_level_advance();
        test_game_done();
        test_restart_from_done();
        test_held_level_complete();
        test_reset_in_hide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
